// File: rtl/spi_pkg.sv
// Shared definitions for the SPI interface subsystem: byte width, arbiter FSM encoding and a
// small sizing helper.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StGap
    } arb_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: returns a one-hot grant for the first valid requester found
// when scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
module spi_rr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan from the pointer with wrap; only the first hit is granted.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PTR_W'((32'(rr_ptr) + k) % NREQ);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one spi_master between NREQ byte-stream requesters. Round-robin between packets, with
// the owner locked in until its last byte has finished; each byte is issued with a single tx_en
// pulse, tracked through spi_busy, and followed by a fixed idle gap.
module spi_master_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned BUSY_TO = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*SPI_BYTE_W-1:0] req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            gnt,
    output logic                       byte_done,
    output logic                       to_err,
    output logic [SPI_BYTE_W-1:0]      tx_data,
    output logic                       tx_en,
    input  logic                       spi_busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(max_u(GAP_CYC, BUSY_TO) + 1);

    arb_state_e            state_q, state_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SPI_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                  last_q, last_d;
    logic                  tx_en_q, tx_en_d;
    logic                  byte_done_q, byte_done_d;
    logic                  to_err_q, to_err_d;

    logic [NREQ-1:0]       arb_gnt;
    logic [PTR_W-1:0]      own_idx;
    logic [PTR_W-1:0]      rr_next;
    logic                  sel_valid;
    logic                  sel_last;
    logic [SPI_BYTE_W-1:0] sel_data;

    spi_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .valid  (req_valid),
        .rr_ptr (rr_q),
        .grant  (arb_gnt)
    );

    // Route the current owner's byte, last flag and valid onto single-lane signals.
    always_comb begin
        own_idx   = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                own_idx   = PTR_W'(i);
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*SPI_BYTE_W +: SPI_BYTE_W];
            end
        end
    end

    // A finished owner drops to lowest priority for the next round.
    assign rr_next = (own_idx == PTR_W'(NREQ - 1)) ? '0 : own_idx + PTR_W'(1);

    // Next-state and registered-output logic for the byte sequencer.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        tx_en_d     = 1'b0;
        byte_done_d = 1'b0;
        to_err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                // A busy engine means someone else owns the bus; do not arbitrate.
                if (!spi_busy && (|req_valid)) begin
                    gnt_d   = arb_gnt;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Owner may stall here indefinitely; the grant is never revoked mid-packet.
                if (sel_valid) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    tx_en_d   = 1'b1;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                // Count starts at 1 so the timeout lands exactly BUSY_TO cycles after tx_en.
                cnt_d   = CNT_W'(1);
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (spi_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q >= CNT_W'(BUSY_TO - 1)) begin
                    to_err_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StGap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitDone: begin
                if (!spi_busy) begin
                    byte_done_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StGap;
                end
            end
            StGap: begin
                if (cnt_q >= CNT_W'(GAP_CYC - 1)) begin
                    if (last_q) begin
                        gnt_d   = '0;
                        rr_d    = rr_next;
                        state_d = StIdle;
                    end else begin
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            last_q      <= 1'b0;
            tx_en_q     <= 1'b0;
            byte_done_q <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            last_q      <= last_d;
            tx_en_q     <= tx_en_d;
            byte_done_q <= byte_done_d;
            to_err_q    <= to_err_d;
        end
    end

    assign req_ready = (state_q == StFetch) ? (gnt_q & req_valid) : '0;
    assign gnt       = gnt_q;
    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign byte_done = byte_done_q;
    assign to_err    = to_err_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter with a behavioural CPOL=0/CPHA=1 SPI engine and MISO looped to
// MOSI. Expected bytes and owners go into a scoreboard when stimulus is queued and are compared
// at tx_en and again when the engine has shifted the byte out.
`timescale 1ns/1ps
module tb_spi_master_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned GAP_CYC = 4;
    localparam int unsigned BUSY_TO = 16;
    localparam int          BUDGET  = 3000;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   gnt;
    logic              byte_done;
    logic              to_err;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              spi_busy;

    always #10 clk = ~clk;

    spi_master_arbiter #(
        .NREQ    (NREQ),
        .GAP_CYC (GAP_CYC),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .gnt       (gnt),
        .byte_done (byte_done),
        .to_err    (to_err),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .spi_busy  (spi_busy)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- requesters ----------------
    typedef struct packed {logic [7:0] data; logic last;} beat_t;
    beat_t rq [NREQ][$];
    logic [NREQ-1:0] acc;

    function automatic void drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() != 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = rq[i][0].data;
                req_last[i]        = rq[i][0].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endfunction

    always @(posedge clk) acc <= req_valid & req_ready;

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        drive_reqs();
    end

    // ---------------- SPI engine model ----------------
    logic       eng_busy, eng_done, mosi;
    logic       mute = 1'b0;
    int         eng_cnt;
    logic [7:0] eng_sh, eng_rx;

    assign spi_busy = eng_busy;

    // 4 clk per bit: SCLK rises at phase 0 (launch MOSI), falls at phase 2 (sample MISO=MOSI).
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eng_busy <= 1'b0;
            eng_done <= 1'b0;
            eng_cnt  <= 0;
            eng_sh   <= 8'h00;
            eng_rx   <= 8'h00;
            mosi     <= 1'b0;
        end else begin
            eng_done <= 1'b0;
            if (!eng_busy) begin
                if (tx_en && !mute) begin
                    eng_busy <= 1'b1;
                    eng_sh   <= tx_data;
                    eng_cnt  <= 0;
                end
            end else begin
                eng_cnt <= eng_cnt + 1;
                if (eng_cnt % 4 == 0) begin
                    mosi   <= eng_sh[7];
                    eng_sh <= {eng_sh[6:0], 1'b0};
                end
                if (eng_cnt % 4 == 2) eng_rx <= {eng_rx[6:0], mosi};
                if (eng_cnt == 31) begin
                    eng_busy <= 1'b0;
                    eng_done <= 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed {logic [1:0] gnt; logic [7:0] data;} exp_t;
    exp_t       exp_q[$];
    logic [7:0] bus_q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         tx_cnt = 0, done_cnt = 0, err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (tx_en) begin
                tx_cnt++;
                check("sb_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("gnt_at_tx_en", 32'(gnt), 32'(mon_e.gnt));
                    check("tx_data", 32'(tx_data), 32'(mon_e.data));
                    if (!mute) bus_q.push_back(mon_e.data);
                end
            end
            if (eng_done) begin
                check("bus_has_entry", 32'(bus_q.size() != 0), 1);
                if (bus_q.size() != 0) check("mosi_byte", 32'(eng_rx), 32'(bus_q.pop_front()));
            end
            if (byte_done) done_cnt++;
            if (to_err) err_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic enqueue(input int r, input logic [7:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.last = last;
        rq[r].push_back(b);
        drive_reqs();
    endtask

    task automatic expect_byte(input int owner, input logic [7:0] d);
        exp_t e;
        e.gnt  = 2'(1 << owner);
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic bit busy_any();
        return exp_q.size() != 0 || bus_q.size() != 0 || rq[0].size() != 0 ||
               rq[1].size() != 0 || gnt != '0 || spi_busy;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_any() && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(n < BUDGET), 1);
        repeat (2) @(negedge clk);
    endtask

    // which: 0 tx_en, 1 byte_done, 2 to_err; returns the cycle it was seen in.
    task automatic wait_for(input int which, input string name, output int at);
        int   n = 0;
        logic hit = 1'b0;
        while (!hit && n < BUDGET) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = tx_en;
                1:       hit = byte_done;
                default: hit = to_err;
            endcase
        end
        check({name, "_seen"}, 32'(hit), 1);
        at = cyc;
    endtask

    task automatic clear_all();
        exp_q.delete();
        bus_q.delete();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        drive_reqs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] mask;
        logic [7:0] d0;
        logic [7:0] d1;
        int         first;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, d0, n0, e0;

        // Round-robin pointer is 1 when the table starts (reset byte goes through owner 0).
        vecs[0] = '{2'b11, 8'h80, 8'h3C, 1};
        vecs[1] = '{2'b01, 8'h01, 8'h00, 0};
        vecs[2] = '{2'b10, 8'h00, 8'hFF, 1};
        vecs[3] = '{2'b11, 8'h5A, 8'hC3, 0};
        vecs[4] = '{2'b10, 8'h00, 8'h81, 1};
        vecs[5] = '{2'b11, 8'h00, 8'h7E, 0};
        vecs[6] = '{2'b01, 8'hA5, 8'h00, 0};
        vecs[7] = '{2'b11, 8'h96, 8'h69, 1};

        drive_reqs();
        enqueue(0, 8'h11, 1'b1);
        expect_byte(0, 8'h11);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_tx_en", 32'(tx_en), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_byte_done", 32'(byte_done), 0);
        check("rst_to_err", 32'(to_err), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        rstn = 1'b1;
        wait_idle("first_byte");

        // Single-byte packets, some simultaneous.
        foreach (vecs[v]) begin
            n0 = done_cnt;
            t0 = tx_cnt;
            if (vecs[v].first == 0) begin
                if (vecs[v].mask[0]) expect_byte(0, vecs[v].d0);
                if (vecs[v].mask[1]) expect_byte(1, vecs[v].d1);
            end else begin
                if (vecs[v].mask[1]) expect_byte(1, vecs[v].d1);
                if (vecs[v].mask[0]) expect_byte(0, vecs[v].d0);
            end
            @(negedge clk);
            if (vecs[v].mask[0]) enqueue(0, vecs[v].d0, 1'b1);
            if (vecs[v].mask[1]) enqueue(1, vecs[v].d1, 1'b1);
            wait_idle("vec");
            check("vec_done_cnt", 32'(done_cnt - n0), 32'($countones(vecs[v].mask)));
            check("vec_tx_cnt", 32'(tx_cnt - t0), 32'($countones(vecs[v].mask)));
        end

        // Packet lock and inter-byte gap, rr back at 0.
        do_reset();
        expect_byte(0, 8'hA5);
        expect_byte(0, 8'h5A);
        expect_byte(1, 8'h81);
        enqueue(0, 8'hA5, 1'b0);
        enqueue(0, 8'h5A, 1'b1);
        enqueue(1, 8'h81, 1'b1);
        wait_for(1, "lock_done0", d0);
        wait_for(0, "lock_tx1", t1);
        check("gap_in_packet", 32'(t1 - d0), GAP_CYC + 1);
        wait_for(1, "lock_done1", d0);
        wait_for(0, "lock_tx2", t1);
        check("gap_new_packet", 32'(t1 - d0), GAP_CYC + 2);
        wait_idle("lock");

        // Both requesters held valid: grants alternate 0,1,0,1.
        n0 = done_cnt;
        expect_byte(0, 8'h10);
        expect_byte(1, 8'h20);
        expect_byte(0, 8'h30);
        expect_byte(1, 8'h40);
        @(negedge clk);
        enqueue(0, 8'h10, 1'b1);
        enqueue(0, 8'h30, 1'b1);
        enqueue(1, 8'h20, 1'b1);
        enqueue(1, 8'h40, 1'b1);
        wait_idle("rr");
        check("rr_done_cnt", 32'(done_cnt - n0), 4);

        // Engine never goes busy on the first byte; the packet must still finish.
        n0 = done_cnt;
        e0 = err_cnt;
        mute = 1'b1;
        expect_byte(0, 8'hC3);
        expect_byte(0, 8'h3C);
        enqueue(0, 8'hC3, 1'b0);
        enqueue(0, 8'h3C, 1'b1);
        wait_for(0, "to_tx", t0);
        wait_for(2, "to_err", t1);
        mute = 1'b0;
        check("to_latency", 32'(t1 - t0), BUSY_TO);
        wait_for(0, "to_next_tx", t0);
        check("to_gap", 32'(t0 - t1), GAP_CYC + 1);
        wait_idle("timeout");
        check("to_err_cnt", 32'(err_cnt - e0), 1);
        check("to_done_cnt", 32'(done_cnt - n0), 1);

        // Asynchronous reset in the middle of a byte.
        expect_byte(0, 8'hE7);
        enqueue(0, 8'hE7, 1'b1);
        wait_for(0, "arst_tx", t0);
        repeat (5) @(negedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 0);
        check("arst_tx_data", 32'(tx_data), 0);
        check("arst_tx_en", 32'(tx_en), 0);
        check("arst_byte_done", 32'(byte_done), 0);
        check("arst_to_err", 32'(to_err), 0);
        check("arst_req_ready", 32'(req_ready), 0);
        clear_all();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Clean transfer afterwards, with first-byte latency from IDLE.
        n0 = done_cnt;
        expect_byte(0, 8'h81);
        enqueue(0, 8'h81, 1'b1);
        t0 = cyc;
        wait_for(0, "post_tx", t1);
        check("idle_latency", 32'(t1 - t0), 2);
        wait_idle("post_reset");
        check("post_done_cnt", 32'(done_cnt - n0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
